// File: rtl/lu_proc_pkg.sv
// lu_proc_pkg: instruction field layout, NOP encoding and issue FSM state type
// shared by the LU pipeline front end.
package lu_proc_pkg;

    localparam int CMD_MSB = 26;
    localparam int CMD_LSB = 24;
    localparam int RES_MSB = 23;
    localparam int RES_LSB = 16;
    localparam int OP1_MSB = 15;
    localparam int OP1_LSB = 8;
    localparam int OP0_MSB = 7;
    localparam int OP0_LSB = 0;

    localparam logic [2:0] CMD_NOP = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } issue_state_t;

endpackage

// File: rtl/issue_prog_ram.sv
// issue_prog_ram: DEPTH x INSTR_SIZE program store with one synchronous write
// port and one asynchronous read port; out-of-range write addresses are dropped.
module issue_prog_ram #(
    parameter int INSTR_SIZE = 27,
    parameter int DEPTH      = 16,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [INSTR_SIZE-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [INSTR_SIZE-1:0] rdata
);

    logic [INSTR_SIZE-1:0] mem [DEPTH];
    logic                  addr_ok;

    if ((2 ** AW) > DEPTH) begin : g_partial
        assign addr_ok = (int'(waddr) < DEPTH);
    end else begin : g_full
        assign addr_ok = 1'b1;
    end

    // NOTE: the array has no reset branch so it maps onto plain RAM cells;
    // its contents survive rst and are only ever defined by writes.
    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (we && addr_ok) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_issue_unit.sv
// instr_issue_unit: program sequencer streaming stored instructions as VLD/INSTR_WORD
// for a programmable number of passes. Define ISSUE_HAZARD_STALL_EN for one-bubble RAW stalls.
module instr_issue_unit
    import lu_proc_pkg::*;
#(
    parameter int INSTR_SIZE = 27,
    parameter int DEPTH      = 16,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  prog_we,
    input  logic [AW-1:0]         prog_addr,
    input  logic [INSTR_SIZE-1:0] prog_data,
    input  logic [AW:0]           prog_len,
    input  logic [7:0]            loop_cnt,
    input  logic                  start,
    input  logic                  hold,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  VLD,
    output logic [INSTR_SIZE-1:0] INSTR_WORD,
    output logic [15:0]           issued_cnt
);

    localparam logic [AW:0]   LEN_MAX = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LEN_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PC_ONE  = AW'(1);

    issue_state_t          state, state_nxt;
    logic [AW-1:0]         pc;
    logic [AW:0]           len_q;
    logic [7:0]            pass_cnt;
    logic                  vld_q;
    logic [INSTR_SIZE-1:0] instr_q;
    logic [INSTR_SIZE-1:0] rd_data;
    logic [15:0]           cnt_q;
    logic                  accept;
    logic                  issue_go;
    logic                  stall;
    logic                  last_in_pass;
    logic [AW:0]           len_clamped;

    issue_prog_ram #(
        .INSTR_SIZE (INSTR_SIZE),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_prog_ram (
        .clk   (clk),
        .we    (prog_we && (state != RUN)),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (pc),
        .rdata (rd_data)
    );

`ifdef ISSUE_HAZARD_STALL_EN
    // Candidate reads a register written by the word on the bus this cycle.
    assign stall = vld_q &&
                   ((rd_data[OP0_MSB:OP0_LSB] == instr_q[RES_MSB:RES_LSB]) ||
                    (rd_data[OP1_MSB:OP1_LSB] == instr_q[RES_MSB:RES_LSB]));
`else
    assign stall = 1'b0;
`endif

    assign len_clamped  = (prog_len > LEN_MAX) ? LEN_MAX : prog_len;
    assign accept       = (state == IDLE) && start && !abort;
    assign issue_go     = (state == RUN) && !abort && (pass_cnt != 8'd0) && !hold && !stall;
    assign last_in_pass = ({1'b0, pc} == (len_q - LEN_ONE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: state_nxt gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (prog_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (pass_cnt == 8'd0) begin
                    // Final word is on the bus this cycle; done follows it directly.
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= '0;
            len_q    <= '0;
            pass_cnt <= '0;
            vld_q    <= 1'b0;
            instr_q  <= '0;
            cnt_q    <= '0;
        end else begin
            vld_q   <= issue_go;
            instr_q <= issue_go ? rd_data : '0;
            if (accept) begin
                pc       <= '0;
                len_q    <= len_clamped;
                pass_cnt <= (loop_cnt == 8'd0) ? 8'd1 : loop_cnt;
                cnt_q    <= '0;
            end else if (issue_go) begin
                if (cnt_q != 16'hFFFF) begin
                    cnt_q <= cnt_q + 16'd1;
                end
                if (last_in_pass) begin
                    pc       <= '0;
                    pass_cnt <= pass_cnt - 8'd1;
                end else begin
                    pc <= pc + PC_ONE;
                end
            end
        end
    end

    assign busy       = (state == RUN);
    assign done       = (state == DONE);
    assign VLD        = vld_q;
    assign INSTR_WORD = instr_q;
    assign issued_cnt = cnt_q;

endmodule

// File: tb/tb_instr_issue_unit.sv
// tb_instr_issue_unit: table-driven bench with a scoreboard of expected issued words
// and hand-written sequences for reset, abort and write/start corner cases.
`timescale 1ns/1ps
module tb_instr_issue_unit;
    import lu_proc_pkg::*;

    localparam int INSTR_SIZE = 27;
    localparam int DEPTH      = 16;
    localparam int AW         = 4;
`ifdef ISSUE_HAZARD_STALL_EN
    localparam int HZ = 1;
`else
    localparam int HZ = 0;
`endif

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  prog_we;
    logic [AW-1:0]         prog_addr;
    logic [INSTR_SIZE-1:0] prog_data;
    logic [AW:0]           prog_len;
    logic [7:0]            loop_cnt;
    logic                  start;
    logic                  hold;
    logic                  abort;
    logic                  busy;
    logic                  done;
    logic                  VLD;
    logic [INSTR_SIZE-1:0] INSTR_WORD;
    logic [15:0]           issued_cnt;

    always #5 clk = ~clk;

    instr_issue_unit #(
        .INSTR_SIZE (INSTR_SIZE),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .prog_len   (prog_len),
        .loop_cnt   (loop_cnt),
        .start      (start),
        .hold       (hold),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .VLD        (VLD),
        .INSTR_WORD (INSTR_WORD),
        .issued_cnt (issued_cnt)
    );

    typedef struct {
        string name;
        int    len;
        int    loops;
        int    hold_after;
        int    hold_cyc;
        int    abort_after;
        int    poke_at;
        int    exp_vld;
        bit    exp_done;
    } vec_t;

    int                    checks   = 0;
    int                    failures = 0;
    logic [INSTR_SIZE-1:0] prog [DEPTH];
    logic [INSTR_SIZE-1:0] sb_q [$];
    vec_t                  vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_prog(input int addr, input logic [INSTR_SIZE-1:0] data);
        prog_we   = 1'b1;
        prog_addr = AW'(addr);
        prog_data = data;
        step();
        prog_we = 1'b0;
        prog[addr] = data;
    endtask

    function automatic int hazard_bubble(input logic [INSTR_SIZE-1:0] prev,
                                         input logic [INSTR_SIZE-1:0] nxt);
        if ((nxt[OP0_MSB:OP0_LSB] == prev[RES_MSB:RES_LSB]) ||
            (nxt[OP1_MSB:OP1_LSB] == prev[RES_MSB:RES_LSB]))
            return HZ;
        return 0;
    endfunction

    task automatic run_case(input string name, input int len, input int loops,
                            input int hold_after, input int hold_cyc,
                            input int abort_after, input int poke_at,
                            input int exp_vld, input bit exp_done,
                            input bit wr_en, input int wr_addr,
                            input logic [INSTR_SIZE-1:0] wr_data);
        logic [INSTR_SIZE-1:0] seq [$];
        int  passes, exp_gap, n_vld, n_done, gap, pending, first_cyc, post, hold_left;
        bit  finished, abort_seen, hold_started, poked, aborting, prev_vld;

        if (wr_en) prog[wr_addr] = wr_data;
        passes = (loops == 0) ? 1 : loops;
        for (int p = 0; p < passes; p++)
            for (int i = 0; i < len; i++)
                seq.push_back(prog[i]);
        if (abort_after > 0)
            while (seq.size() > abort_after) void'(seq.pop_back());
        exp_gap = (hold_cyc > 0 && hold_after < seq.size()) ? hold_cyc : 0;
        for (int i = 1; i < seq.size(); i++)
            if (!(hold_cyc > 0 && i == hold_after))
                exp_gap += hazard_bubble(seq[i-1], seq[i]);
        foreach (seq[i]) sb_q.push_back(seq[i]);

        prog_len = (AW+1)'(len);
        loop_cnt = 8'(loops);
        start    = 1'b1;
        if (wr_en) begin
            prog_we   = 1'b1;
            prog_addr = AW'(wr_addr);
            prog_data = wr_data;
        end
        step();
        start   = 1'b0;
        prog_we = 1'b0;
        check({name, " busy@start"}, busy, len != 0);
        check({name, " no VLD on start edge"}, VLD, 0);

        n_vld = 0; n_done = 0; gap = 0; pending = 0; first_cyc = -1; post = 0; hold_left = 0;
        finished = 0; abort_seen = 0; hold_started = 0; poked = 0; aborting = 0; prev_vld = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (VLD) begin
                if (first_cyc < 0) first_cyc = cyc;
                n_vld++;
                gap += pending;
                pending = 0;
                if (sb_q.size() == 0) check({name, " extra VLD"}, VLD, 0);
                else                  check({name, " word"}, INSTR_WORD, sb_q.pop_front());
            end else begin
                if (n_vld > 0) pending++;
                check({name, " word zero w/o VLD"}, INSTR_WORD, 0);
            end
            if (done) begin
                n_done++;
                finished = 1;
                check({name, " busy@done"}, busy, 0);
                check({name, " done follows last VLD"}, prev_vld, exp_vld > 0);
            end
            prev_vld = VLD;
            if (finished || abort_seen) post++;
            if (post > 3) break;

            if (hold_cyc > 0 && n_vld == hold_after && !hold_started) begin
                hold = 1'b1;
                hold_left = hold_cyc;
                hold_started = 1;
            end
            if (abort_after > 0 && n_vld == abort_after && !aborting) begin
                abort = 1'b1;
                aborting = 1;
            end
            if (poke_at > 0 && n_vld == poke_at && !poked) begin
                start     = 1'b1;
                prog_we   = 1'b1;
                prog_addr = AW'(1);
                prog_data = 27'h7FFFFFF;
                poked = 1;
            end
            step();
            start   = 1'b0;
            prog_we = 1'b0;
            if (hold_left > 0) begin
                hold_left--;
                if (hold_left == 0) hold = 1'b0;
            end
            if (abort) begin
                abort = 1'b0;
                abort_seen = 1;
                check({name, " VLD after abort"}, VLD, 0);
                check({name, " busy after abort"}, busy, 0);
            end
        end
        hold = 1'b0;
        check({name, " completed"}, finished || abort_seen, 1);
        if (exp_vld > 0) check({name, " first VLD latency"}, first_cyc, 1);
        check({name, " VLD count"}, n_vld, exp_vld);
        check({name, " done count"}, n_done, exp_done);
        check({name, " gap cycles"}, gap, exp_gap);
        check({name, " issued_cnt"}, issued_cnt, exp_vld);
        check({name, " scoreboard empty"}, sb_q.size(), 0);
        sb_q.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{"one_pass",   3, 1, 0, 0, 0, 0, 3, 1'b1};
        vecs[1] = '{"two_pass",   3, 2, 0, 0, 0, 2, 6, 1'b1};
        vecs[2] = '{"zero_loops", 3, 0, 0, 0, 0, 0, 3, 1'b1};
        vecs[3] = '{"zero_len",   0, 1, 0, 0, 0, 0, 0, 1'b1};
        vecs[4] = '{"hold2",      3, 1, 2, 2, 0, 0, 3, 1'b1};
        vecs[5] = '{"abort1",     3, 1, 0, 0, 1, 0, 1, 1'b0};
        vecs[6] = '{"len2_x3",    2, 3, 0, 0, 0, 0, 6, 1'b1};
        vecs[7] = '{"len1_x4",    1, 4, 0, 0, 0, 0, 4, 1'b1};

        rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        prog_len = '0; loop_cnt = '0; start = 1'b0; hold = 1'b0; abort = 1'b0;
        #12;
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst VLD", VLD, 0);
        check("rst INSTR_WORD", INSTR_WORD, 0);
        check("rst issued_cnt", issued_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        step();

        write_prog(0, 27'h0020100);
        write_prog(1, 27'h1030201);
        write_prog(2, 27'h2040302);

        for (int v = 0; v < 8; v++)
            run_case(vecs[v].name, vecs[v].len, vecs[v].loops, vecs[v].hold_after,
                     vecs[v].hold_cyc, vecs[v].abort_after, vecs[v].poke_at,
                     vecs[v].exp_vld, vecs[v].exp_done, 1'b0, 0, '0);

        // Write and start in the same cycle: the new word must be issued.
        run_case("write_with_start", 1, 1, 0, 0, 0, 0, 1, 1'b1, 1'b1, 0, 27'h3ABCDEF);
        write_prog(0, 27'h0020100);

        // start and abort together in IDLE: abort wins.
        prog_len = (AW+1)'(3);
        loop_cnt = 8'd1;
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        check("start+abort busy", busy, 0);
        check("start+abort done", done, 0);
        step();
        check("start+abort VLD", VLD, 0);
        check("start+abort issued_cnt kept", issued_cnt, 1);

        // Asynchronous reset mid-run clears outputs at once; RAM survives.
        prog_len = (AW+1)'(3);
        loop_cnt = 8'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("pre-reset VLD", VLD, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async rst busy", busy, 0);
        check("async rst VLD", VLD, 0);
        check("async rst INSTR_WORD", INSTR_WORD, 0);
        check("async rst issued_cnt", issued_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        step();
        run_case("after_reset", 3, 1, 0, 0, 0, 0, 3, 1'b1, 1'b0, 0, '0);

        // Back-to-back RAW dependency: one bubble only when stalls are enabled.
        write_prog(0, 27'h0050000);
        write_prog(1, 27'h1060005);
        run_case("raw_pair", 2, 1, 0, 0, 0, 0, 2, 1'b1, 1'b0, 0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
